hdlc_rx_deframer: RTL and testbench

Parametrised HDLC receive deframer, the next-generation receive front end of the Hdlc controller. It takes the serial Rx line and performs flag and abort detection, zero-bit removal and LSB-first byte assembly. It checks a selectable FCS (none, CRC-16 or CRC-32) and emits payload bytes plus frame status toward the Rx buffer/register logic. It generalises the fixed-size, CRC-16-only receive path with configurable FCS mode and maximum frame length.

---
 rtl/hdlc_rx_deframer_if.sv | 31 +++
 rtl/hdlc_rx_deframer.sv | 239 +++++++++++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_rx_deframer_if.sv
// Signal bundle between the serial Rx line driver and the HDLC receive deframer.
interface hdlc_rx_deframer_if #(
    parameter int unsigned SIZE_W = 8
) ();
    logic              Rx;
    logic              RxEN;
    logic [7:0]        Rx_Data;
    logic              Rx_NewByte;
    logic              Rx_FlagDetect;
    logic              Rx_AbortDetect;
    logic              Rx_ValidFrame;
    logic              Rx_EoF;
    logic [SIZE_W-1:0] Rx_FrameSize;
    logic              Rx_Overflow;
    logic              Rx_FCSerr;
    logic              Rx_FrameError;

    // Line side: drives the serial data, observes deframer results.
    modport master (
        output Rx, RxEN,
        input  Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
        input  Rx_EoF, Rx_FrameSize, Rx_Overflow, Rx_FCSerr, Rx_FrameError
    );

    // Deframer side.
    modport slave (
        input  Rx, RxEN,
        output Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
        output Rx_EoF, Rx_FrameSize, Rx_Overflow, Rx_FCSerr, Rx_FrameError
    );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero-bit removal, LSB-first byte
// assembly, FCS holdback and CRC-16/CRC-32 residue check.
module hdlc_rx_deframer #(
    parameter int unsigned MAX_BYTES = 128,
    parameter int unsigned FCS_MODE  = 1,
    parameter int unsigned SIZE_W    = 8
) (
    input logic               Clk,
    input logic               Rst,
    hdlc_rx_deframer_if.slave bus
);
    localparam int unsigned FCS_BYTES = (FCS_MODE == 2) ? 4 : (FCS_MODE == 1) ? 2 : 0;
    localparam int unsigned HB_D      = (FCS_BYTES == 0) ? 1 : FCS_BYTES;
    localparam logic [31:0] CRC_POLY  = (FCS_MODE == 2) ? 32'hEDB88320 : 32'h00008408;
    localparam logic [31:0] CRC_INIT  = (FCS_MODE == 2) ? 32'hFFFFFFFF : 32'h0000FFFF;
    localparam logic [31:0] CRC_GOOD  = (FCS_MODE == 2) ? 32'hDEBB20E3 : 32'h0000F0B8;
    localparam logic [7:0]  MAX_B     = 8'(MAX_BYTES);
    localparam logic [2:0]  RCV_MIN   = 3'(FCS_BYTES + 1);
    localparam logic [2:0]  HB_FULL   = 3'(FCS_BYTES);

    typedef enum logic [1:0] {StHunt, StSync, StFrame} state_e;

    state_e            state_q;
    logic [7:0]        win_q;
    logic [2:0]        ones_q;
    logic [3:0]        skip_q;      // flag bits still travelling through the delay line
    logic [2:0]        dst_ones_q;
    logic [2:0]        bit_cnt_q;
    logic [2:0]        rcv_cnt_q;   // received bytes incl. FCS, saturating at RCV_MIN
    logic [7:0]        byte_sr_q;
    logic [31:0]       crc_q;
    logic [7:0]        hb_q [HB_D];
    logic [2:0]        hb_fill_q;
    logic [7:0]        pay_cnt_q;

    logic [7:0]        data_q;
    logic              new_byte_q, flag_q, abort_q, valid_q, eof_q;
    logic              ovf_q, fcserr_q, ferr_q;
    logic [SIZE_W-1:0] size_q;

    logic [7:0]  win_d;
    logic [2:0]  ones_d;
    logic        out_bit, flag_hit, abort_hit, data_bit, step, clr;
    logic        stuffed, byte_done, out_valid, pay_ok, frame_err, fcs_err;
    logic [2:0]  dst_ones_d, bit_cnt_d, rcv_cnt_d, hb_fill_d;
    logic [7:0]  byte_sr_d, out_byte, pay_cnt_d;
    logic [31:0] crc_d;
    logic [7:0]  hb_d [HB_D];

    // Detector window doubles as the 8-sample delay line; win_q[0] is the bit leaving it.
    always_comb begin
        win_d     = {bus.Rx, win_q[7:1]};
        out_bit   = win_q[0];
        flag_hit  = (win_d == 8'h7E);
        abort_hit = bus.Rx && (ones_q == 3'd6);
        if (!bus.Rx) begin
            ones_d = 3'd0;
        end else if (ones_q == 3'd7) begin
            ones_d = ones_q;
        end else begin
            ones_d = ones_q + 3'd1;
        end
        data_bit = (state_q != StHunt) && (skip_q == 4'd0);
        step     = bus.RxEN && data_bit && !abort_hit;
        clr      = bus.RxEN && (flag_hit || (abort_hit && state_q != StHunt));
    end

    // Destuff, assemble and CRC the bit leaving the delay line.
    always_comb begin
        stuffed    = !out_bit && (dst_ones_q == 3'd5);
        dst_ones_d = 3'd0;
        bit_cnt_d  = bit_cnt_q;
        byte_sr_d  = byte_sr_q;
        crc_d      = crc_q;
        byte_done  = 1'b0;
        if (!stuffed) begin
            if (out_bit) begin
                dst_ones_d = (dst_ones_q == 3'd7) ? dst_ones_q : dst_ones_q + 3'd1;
            end
            byte_sr_d = {out_bit, byte_sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            crc_d     = (crc_q >> 1) ^ ((crc_q[0] ^ out_bit) ? CRC_POLY : 32'h0);
            byte_done = (bit_cnt_q == 3'd7);
        end
        rcv_cnt_d = (byte_done && rcv_cnt_q < RCV_MIN) ? rcv_cnt_q + 3'd1 : rcv_cnt_q;
    end

    // Holdback FIFO keeps the trailing FCS bytes away from the payload output.
    always_comb begin
        hb_d      = hb_q;
        hb_fill_d = hb_fill_q;
        out_valid = 1'b0;
        out_byte  = byte_sr_d;
        if (byte_done) begin
            if (FCS_BYTES == 0) begin
                out_valid = 1'b1;
            end else if (hb_fill_q == HB_FULL) begin
                out_valid = 1'b1;
                out_byte  = hb_q[0];
                for (int i = 0; i < HB_D - 1; i++) begin
                    hb_d[i] = hb_q[i+1];
                end
                hb_d[HB_D-1] = byte_sr_d;
            end else begin
                for (int i = 0; i < HB_D; i++) begin
                    if (3'(i) == hb_fill_q) begin
                        hb_d[i] = byte_sr_d;
                    end
                end
                hb_fill_d = hb_fill_q + 3'd1;
            end
        end
        pay_ok    = out_valid && (pay_cnt_q < MAX_B);
        pay_cnt_d = pay_cnt_q + {7'd0, pay_ok};
        frame_err = (bit_cnt_d != 3'd0) || (rcv_cnt_d < RCV_MIN);
        fcs_err   = (FCS_MODE != 0) && !frame_err && (crc_d != CRC_GOOD);
    end

    // Per-frame datapath registers: restart on any flag or abort, advance on data bits.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dst_ones_q <= 3'd0;
            bit_cnt_q  <= 3'd0;
            rcv_cnt_q  <= 3'd0;
            byte_sr_q  <= 8'd0;
            crc_q      <= CRC_INIT;
            hb_q       <= '{default: 8'd0};
            hb_fill_q  <= 3'd0;
            pay_cnt_q  <= 8'd0;
        end else if (clr) begin
            dst_ones_q <= 3'd0;
            bit_cnt_q  <= 3'd0;
            rcv_cnt_q  <= 3'd0;
            byte_sr_q  <= 8'd0;
            crc_q      <= CRC_INIT;
            hb_fill_q  <= 3'd0;
            pay_cnt_q  <= 8'd0;
        end else if (step) begin
            dst_ones_q <= dst_ones_d;
            bit_cnt_q  <= bit_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            byte_sr_q  <= byte_sr_d;
            crc_q      <= crc_d;
            hb_q       <= hb_d;
            hb_fill_q  <= hb_fill_d;
            pay_cnt_q  <= pay_cnt_d;
        end
    end

    // Frame FSM with registered strobes and status levels.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= StHunt;
            win_q      <= 8'd0;
            ones_q     <= 3'd0;
            skip_q     <= 4'd0;
            data_q     <= 8'd0;
            new_byte_q <= 1'b0;
            flag_q     <= 1'b0;
            abort_q    <= 1'b0;
            valid_q    <= 1'b0;
            eof_q      <= 1'b0;
            ovf_q      <= 1'b0;
            fcserr_q   <= 1'b0;
            ferr_q     <= 1'b0;
            size_q     <= '0;
        end else begin
            new_byte_q <= 1'b0;
            flag_q     <= 1'b0;
            abort_q    <= 1'b0;
            eof_q      <= 1'b0;
            if (bus.RxEN) begin
                win_q  <= win_d;
                ones_q <= ones_d;
                if (skip_q != 4'd0) begin
                    skip_q <= skip_q - 4'd1;
                end
                if (flag_hit) begin
                    flag_q <= 1'b1;
                    skip_q <= 4'd8;
                end
                unique case (state_q)
                    StHunt: begin
                        if (flag_hit) begin
                            state_q <= StSync;
                        end
                    end
                    StSync, StFrame: begin
                        if (abort_hit) begin
                            abort_q <= 1'b1;
                            valid_q <= 1'b0;
                            state_q <= StHunt;
                        end else begin
                            if (data_bit) begin
                                if (state_q == StSync) begin
                                    valid_q  <= 1'b1;
                                    ovf_q    <= 1'b0;
                                    fcserr_q <= 1'b0;
                                    ferr_q   <= 1'b0;
                                    state_q  <= StFrame;
                                end
                                if (pay_ok) begin
                                    new_byte_q <= 1'b1;
                                    data_q     <= out_byte;
                                end
                                if (out_valid && !pay_ok) begin
                                    ovf_q <= 1'b1;
                                end
                            end
                            // Closing flag also opens the next frame, hence back to sync.
                            if (flag_hit) begin
                                state_q <= StSync;
                                if (data_bit) begin
                                    eof_q    <= 1'b1;
                                    valid_q  <= 1'b0;
                                    size_q   <= SIZE_W'(pay_cnt_d);
                                    ferr_q   <= frame_err;
                                    fcserr_q <= fcs_err;
                                end
                            end
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

    assign bus.Rx_Data        = data_q;
    assign bus.Rx_NewByte     = new_byte_q;
    assign bus.Rx_FlagDetect  = flag_q;
    assign bus.Rx_AbortDetect = abort_q;
    assign bus.Rx_ValidFrame  = valid_q;
    assign bus.Rx_EoF         = eof_q;
    assign bus.Rx_FrameSize   = size_q;
    assign bus.Rx_Overflow    = ovf_q;
    assign bus.Rx_FCSerr      = fcserr_q;
    assign bus.Rx_FrameError  = ferr_q;
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: three configurations (CRC-16, CRC-16 with 4-byte limit,
// CRC-32) fed from a frame builder that computes FCS and bit stuffing from scratch.
module tb_hdlc_rx_deframer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic rx_v = 1'b1;
    logic en_v = 1'b0;
    int   sel  = 0;

    hdlc_rx_deframer_if #(.SIZE_W(8)) if16 ();
    hdlc_rx_deframer_if #(.SIZE_W(8)) if4 ();
    hdlc_rx_deframer_if #(.SIZE_W(8)) if32 ();

    assign if16.Rx   = (sel == 0) ? rx_v : 1'b1;
    assign if16.RxEN = (sel == 0) ? en_v : 1'b0;
    assign if4.Rx    = (sel == 1) ? rx_v : 1'b1;
    assign if4.RxEN  = (sel == 1) ? en_v : 1'b0;
    assign if32.Rx   = (sel == 2) ? rx_v : 1'b1;
    assign if32.RxEN = (sel == 2) ? en_v : 1'b0;

    hdlc_rx_deframer #(.MAX_BYTES(128), .FCS_MODE(1), .SIZE_W(8)) dut16 (
        .Clk(clk), .Rst(rst), .bus(if16));
    hdlc_rx_deframer #(.MAX_BYTES(4), .FCS_MODE(1), .SIZE_W(8)) dut4 (
        .Clk(clk), .Rst(rst), .bus(if4));
    hdlc_rx_deframer #(.MAX_BYTES(128), .FCS_MODE(2), .SIZE_W(8)) dut32 (
        .Clk(clk), .Rst(rst), .bus(if32));

    // Packed outputs: data[23:16] new[15] flag[14] abort[13] valid[12] eof[11]
    // size[10:3] ovf[2] fcserr[1] ferr[0]
    logic [23:0] o16, o4, o32, mon;
    assign o16 = {if16.Rx_Data, if16.Rx_NewByte, if16.Rx_FlagDetect, if16.Rx_AbortDetect,
                  if16.Rx_ValidFrame, if16.Rx_EoF, if16.Rx_FrameSize, if16.Rx_Overflow,
                  if16.Rx_FCSerr, if16.Rx_FrameError};
    assign o4  = {if4.Rx_Data, if4.Rx_NewByte, if4.Rx_FlagDetect, if4.Rx_AbortDetect,
                  if4.Rx_ValidFrame, if4.Rx_EoF, if4.Rx_FrameSize, if4.Rx_Overflow,
                  if4.Rx_FCSerr, if4.Rx_FrameError};
    assign o32 = {if32.Rx_Data, if32.Rx_NewByte, if32.Rx_FlagDetect, if32.Rx_AbortDetect,
                  if32.Rx_ValidFrame, if32.Rx_EoF, if32.Rx_FrameSize, if32.Rx_Overflow,
                  if32.Rx_FCSerr, if32.Rx_FrameError};
    assign mon = (sel == 1) ? o4 : (sel == 2) ? o32 : o16;

    // Observed events from the selected instance.
    logic [7:0] rx_q[$];
    int eof_cnt = 0, flag_cnt = 0, abort_cnt = 0, ovf_at = -1;
    always @(negedge clk) begin
        if (mon[15]) rx_q.push_back(mon[23:16]);
        if (mon[14]) flag_cnt++;
        if (mon[13]) abort_cnt++;
        if (mon[11]) eof_cnt++;
        if (mon[2] && ovf_at < 0) ovf_at = rx_q.size();
    end

    int errors = 0, checks = 0;
    logic [7:0] pay_q[$];
    bit raw_q[$];
    bit tx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic b, input logic en);
        rx_v = b;
        en_v = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sample(1'b1, 1'b0);
    endtask

    task automatic send_range(input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++) begin
            repeat (gap) sample(1'b1, 1'b0);
            sample(tx_q[i], 1'b1);
        end
    endtask

    task automatic add_flag();
        tx_q.push_back(1'b0);
        repeat (6) tx_q.push_back(1'b1);
        tx_q.push_back(1'b0);
    endtask

    // Payload bits LSB first, then the complemented CRC LSB first; optional bit flip.
    task automatic make_raw(input int mode, input int flip);
        logic [31:0] c, poly;
        logic fb;
        int nf;
        poly = (mode == 2) ? 32'hEDB88320 : 32'h00008408;
        c    = (mode == 2) ? 32'hFFFFFFFF : 32'h0000FFFF;
        nf   = (mode == 2) ? 4 : (mode == 1) ? 2 : 0;
        raw_q = {};
        foreach (pay_q[i]) for (int k = 0; k < 8; k++) raw_q.push_back(pay_q[i][k]);
        foreach (raw_q[i]) begin
            fb = c[0] ^ raw_q[i];
            c  = c >> 1;
            if (fb) c = c ^ poly;
        end
        c = ~c;
        for (int k = 0; k < 8 * nf; k++) raw_q.push_back(c[k]);
        if (flip >= 0) raw_q[flip] = !raw_q[flip];
    endtask

    task automatic stuff_and_frame(input bit close);
        int ones;
        tx_q = {};
        add_flag();
        ones = 0;
        foreach (raw_q[i]) begin
            tx_q.push_back(raw_q[i]);
            if (raw_q[i]) begin
                ones++;
                if (ones == 5) begin
                    tx_q.push_back(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        if (close) add_flag();
    endtask

    task automatic rand_payload(input int n);
        pay_q = {};
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    int eof_base, flag_base, abort_base;

    task automatic run_frame(input int s, input int mode, input int flip, input int gap);
        sel = s;
        make_raw(mode, flip);
        stuff_and_frame(1'b1);
        rx_q = {};
        eof_base  = eof_cnt;
        flag_base = flag_cnt;
        send_range(0, tx_q.size(), gap);
        idle(4);
    endtask

    task automatic check_frame(input string tag, input int n_del, input int size,
                               input bit ovf, input bit fcs, input bit ferr);
        check({tag, "_nbytes"}, rx_q.size(), n_del);
        for (int i = 0; i < n_del; i++)
            if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), rx_q[i], pay_q[i]);
        check({tag, "_eof"}, eof_cnt - eof_base, 1);
        check({tag, "_size"}, mon[10:3], size);
        check({tag, "_ovf"}, mon[2], ovf);
        check({tag, "_fcserr"}, mon[1], fcs);
        check({tag, "_ferr"}, mon[0], ferr);
        check({tag, "_valid"}, mon[12], 0);
    endtask

    initial begin
        int n, half;
        idle(3);
        check("reset16", o16, 0);
        check("reset4", o4, 0);
        check("reset32", o32, 0);
        rst = 1'b0;
        idle(2);

        // Fixed frame with bytes that need stuffing, good CRC-16.
        pay_q = '{8'h01, 8'h7E, 8'hFF};
        run_frame(0, 1, -1, 0);
        check_frame("crc16_ok", 3, 3, 0, 0, 0);
        check("crc16_ok_flags", flag_cnt - flag_base, 2);

        // Same frame with an FCS bit flipped.
        run_frame(0, 1, 29, 0);
        check_frame("crc16_bad", 3, 3, 0, 1, 0);

        // Abort after two payload bytes.
        rand_payload(2);
        make_raw(0, -1);
        stuff_and_frame(1'b0);
        rx_q = {};
        eof_base   = eof_cnt;
        abort_base = abort_cnt;
        send_range(0, tx_q.size(), 0);
        check("abort_valid_mid", mon[12], 1);
        tx_q = {};
        repeat (8) tx_q.push_back(1'b1);
        send_range(0, tx_q.size(), 0);
        idle(3);
        check("abort_pulse", abort_cnt - abort_base, 1);
        check("abort_no_eof", eof_cnt - eof_base, 0);
        check("abort_valid", mon[12], 0);
        check("abort_size_held", mon[10:3], 3);
        check("abort_nbytes", rx_q.size(), 0);

        // Random good frames, the first straight after the abort.
        for (int f = 0; f < 3; f++) begin
            n = $urandom_range(1, 8);
            rand_payload(n);
            run_frame(0, 1, -1, 0);
            check_frame($sformatf("rand%0d", f), n, n, 0, 0, 0);
        end

        // Overflow on the 4-byte instance.
        rand_payload(6);
        ovf_at = -1;
        run_frame(1, 1, -1, 0);
        check_frame("ovf", 4, 4, 1, 0, 1'b0);
        check("ovf_at", ovf_at, 4);

        // Closing flag after 19 destuffed bits.
        sel = 0;
        raw_q = {};
        for (int i = 0; i < 19; i++) raw_q.push_back(1'($urandom));
        stuff_and_frame(1'b1);
        rx_q = {};
        eof_base = eof_cnt;
        send_range(0, tx_q.size(), 0);
        idle(4);
        check_frame("short", 0, 0, 0, 0, 1);

        // Back-to-back flags.
        tx_q = {};
        repeat (3) add_flag();
        eof_base  = eof_cnt;
        flag_base = flag_cnt;
        send_range(0, tx_q.size(), 0);
        idle(3);
        check("flags3_count", flag_cnt - flag_base, 3);
        check("flags3_no_eof", eof_cnt - eof_base, 0);

        // CRC-32 frame with RxEN high one cycle in three.
        rand_payload(5);
        run_frame(2, 2, -1, 2);
        check_frame("crc32", 5, 5, 0, 0, 0);

        // Reset in the middle of the next CRC-32 frame.
        rand_payload(5);
        make_raw(2, -1);
        stuff_and_frame(1'b1);
        eof_base = eof_cnt;
        half = tx_q.size() / 2;
        send_range(0, half, 2);
        check("rst_pre_valid", mon[12], 1);
        rst = 1'b1;
        sample(1'b1, 1'b0);
        check("rst_mid", o32, 0);
        rst = 1'b0;
        send_range(half, tx_q.size(), 2);
        idle(4);
        check("rst_no_eof", eof_cnt - eof_base, 0);
        check("rst_after", o32, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
